// File: rtl/relogio_param.sv
// relogio_param: HH:MM:SS clock with configurable tick divider,
// run/pause, validated time load and 12 h / 24 h display.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   run              1 = time advances, 0 = counter and time frozen
//   load, load_h/m/s one-cycle load request, binary 24 h time
//   load_ack/err     one-cycle result pulses, cycle after load
//   sec_tick         one-cycle pulse per advanced second
//   pm               internal hour is 12..23 (aligned with displays)
//   bcd_*            active-low seven-segment digits, bit0 = a
module relogio_param #(
  parameter int DIV = 50_000_000,
  parameter bit MODE_12H = 1'b0,
  parameter int DIV_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] load_h,
  input  logic [5:0] load_m,
  input  logic [5:0] load_s,
  output logic       load_ack,
  output logic       load_err,
  output logic       sec_tick,
  output logic       pm,
  output logic [6:0] bcd_s_unid,
  output logic [6:0] bcd_s_dez,
  output logic [6:0] bcd_m_unid,
  output logic [6:0] bcd_m_dez,
  output logic [6:0] bcd_h_unid,
  output logic [6:0] bcd_h_dez
);

  localparam logic [DIV_W-1:0] TOP = DIV_W'(DIV - 1);

  function automatic logic [2:0] tens(input logic [5:0] v);
    logic [2:0] t;
    t = 3'd0;
    for (int i = 1; i < 6; i++)
      if (v >= 6'(10 * i)) t = 3'(i);
    return t;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [DIV_W-1:0] cnt;
  logic [3:0] s_lsd, m_lsd, h_lsd;
  logic [2:0] s_msd, m_msd;
  logic [1:0] h_msd;

  logic wrap, ld_ok, take;
  logic s_l9, s_m5, m_l9, m_m5, h_23;
  logic c_m, c_h;
  logic [2:0] ls_t, lm_t;
  logic [1:0] lh_t;
  logic [3:0] ls_u, lm_u, lh_u;

  assign wrap  = run && (cnt == TOP);
  assign ld_ok = (load_h <= 5'd23) && (load_m <= 6'd59)
              && (load_s <= 6'd59);
  assign take  = load && ld_ok;

  assign ls_t = tens(load_s);
  assign lm_t = tens(load_m);
  assign lh_t = (load_h >= 5'd20) ? 2'd2 :
                (load_h >= 5'd10) ? 2'd1 : 2'd0;
  assign ls_u = 4'(load_s - 6'(10 * ls_t));
  assign lm_u = 4'(load_m - 6'(10 * lm_t));
  assign lh_u = 4'(load_h - 5'(10 * lh_t));

  assign s_l9 = s_lsd == 4'd9;
  assign s_m5 = s_msd == 3'd5;
  assign m_l9 = m_lsd == 4'd9;
  assign m_m5 = m_msd == 3'd5;
  assign h_23 = (h_msd == 2'd2) && (h_lsd == 4'd3);
  assign c_m  = wrap && s_l9 && s_m5;
  assign c_h  = c_m && m_l9 && m_m5;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sec_tick <= 1'b0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
      s_lsd    <= '0;
      s_msd    <= '0;
      m_lsd    <= '0;
      m_msd    <= '0;
      h_lsd    <= '0;
      h_msd    <= '0;
    end else begin
      // the tick pulse survives a same-cycle load; only the
      // increment is dropped
      sec_tick <= wrap;
      load_ack <= take;
      load_err <= load && !ld_ok;
      if (take)
        cnt <= '0;
      else if (run)
        cnt <= wrap ? '0 : cnt + DIV_W'(1);
      if (take) begin
        s_lsd <= ls_u;
        s_msd <= ls_t;
        m_lsd <= lm_u;
        m_msd <= lm_t;
        h_lsd <= lh_u;
        h_msd <= lh_t;
      end else begin
        if (wrap)
          s_lsd <= s_l9 ? 4'd0 : s_lsd + 4'd1;
        if (wrap && s_l9)
          s_msd <= s_m5 ? 3'd0 : s_msd + 3'd1;
        if (c_m)
          m_lsd <= m_l9 ? 4'd0 : m_lsd + 4'd1;
        if (c_m && m_l9)
          m_msd <= m_m5 ? 3'd0 : m_msd + 3'd1;
        if (c_h) begin
          if (h_23) begin
            h_msd <= 2'd0;
            h_lsd <= 4'd0;
          end else if (h_lsd == 4'd9) begin
            h_msd <= h_msd + 2'd1;
            h_lsd <= 4'd0;
          end else begin
            h_lsd <= h_lsd + 4'd1;
          end
        end
      end
    end
  end

  logic [3:0] dh, dl;
  logic pm_n;

  assign pm_n = (h_msd == 2'd2)
             || ((h_msd == 2'd1) && (h_lsd >= 4'd2));

  // 12 h view: 00 -> 12, 13..19 -> 01..07,
  // 20..21 -> 08..09, 22..23 -> 10..11
  always_comb begin
    dh = {2'b00, h_msd};
    dl = h_lsd;
    if (MODE_12H) begin
      unique case (1'b1)
        (h_msd == 2'd0) && (h_lsd == 4'd0): begin
          dh = 4'd1;
          dl = 4'd2;
        end
        (h_msd == 2'd0) && (h_lsd != 4'd0): begin
          dh = 4'd0;
          dl = h_lsd;
        end
        (h_msd == 2'd1) && (h_lsd <= 4'd2): begin
          dh = 4'd1;
          dl = h_lsd;
        end
        (h_msd == 2'd1) && (h_lsd > 4'd2): begin
          dh = 4'd0;
          dl = h_lsd - 4'd2;
        end
        (h_msd == 2'd2) && (h_lsd <= 4'd1): begin
          dh = 4'd0;
          dl = h_lsd + 4'd8;
        end
        (h_msd == 2'd2) && (h_lsd > 4'd1): begin
          dh = 4'd1;
          dl = h_lsd - 4'd2;
        end
        default: begin
          dh = 4'd0;
          dl = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm         <= 1'b0;
      bcd_s_unid <= seg7(4'd0);
      bcd_s_dez  <= seg7(4'd0);
      bcd_m_unid <= seg7(4'd0);
      bcd_m_dez  <= seg7(4'd0);
      bcd_h_unid <= MODE_12H ? seg7(4'd2) : seg7(4'd0);
      bcd_h_dez  <= MODE_12H ? seg7(4'd1) : seg7(4'd0);
    end else begin
      pm         <= pm_n;
      bcd_s_unid <= seg7(s_lsd);
      bcd_s_dez  <= seg7({1'b0, s_msd});
      bcd_m_unid <= seg7(m_lsd);
      bcd_m_dez  <= seg7({1'b0, m_msd});
      bcd_h_unid <= seg7(dl);
      bcd_h_dez  <= seg7(dh);
    end
  end

endmodule

// File: doc/relogio_param.md
# relogio_param

Parametrised successor to the fixed 24 h HH:MM:SS clock top. It counts seconds, minutes and hours from a single system clock using an internal tick divider with a configurable division ratio. It adds a run/pause control, a validated time-load handshake and a 12 h/24 h display mode. The six digits drive active-low seven-segment displays; the block sits directly under the board top level.

## Interface
Parameters:
- `DIV`, default 50_000_000: `clk` cycles per one-second tick; legal range ≥ 1. `DIV` = 1 ticks every cycle, for simulation.
- `MODE_12H`, default 0: 0 selects 24 h display, 1 selects 12 h display with `pm` flag.
- `DIV_W`, default `$clog2(DIV)` (minimum 1): width of the tick counter.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: 1 lets the time advance; 0 freezes the tick counter and the time.
- `load` in 1: single-cycle request to load `load_h`/`load_m`/`load_s`.
- `load_h` in 5: hours, binary 0–23 (24 h form, regardless of `MODE_12H`).
- `load_m` in 6: minutes, binary 0–59.
- `load_s` in 6: seconds, binary 0–59.
- `load_ack` out 1: one-cycle pulse; the load was accepted.
- `load_err` out 1: one-cycle pulse; the load was rejected as out of range.
- `sec_tick` out 1: one-cycle pulse each time seconds advance.
- `pm` out 1: 1 when the internal hour is 12–23; valid in both modes.
- `bcd_s_unid`, `bcd_s_dez`, `bcd_m_unid`, `bcd_m_dez`, `bcd_h_unid`, `bcd_h_dez` out 7 each: active-low segments, bit0 = a … bit6 = g.

## Operation
- Time state is held as BCD digit registers: s_lsd[3:0], s_msd[2:0], m_lsd[3:0], m_msd[2:0], h_lsd[3:0], h_msd[1:0]. Hours are always 00–23 internally.
- Tick counter:
  - With `run`=1 it counts 0..DIV-1. At DIV-1 it returns to 0 and `sec_tick` asserts for that cycle.
  - With `run`=0 it holds its value and no ticks occur.
- Carry chain on `sec_tick`:
  - s_lsd 9 → 0 carries into s_msd; s_msd 5 with s_lsd 9 → seconds 00 and a minute carry.
  - Minutes use the same rule and produce an hour carry.
  - Hours 09 → 10, 19 → 20, 23 → 00. All carries resolve in the same edge: 23:59:59 → 00:00:00 on one tick.
- Load:
  - On a cycle with `load`=1, all three fields are checked: h ≤ 23, m ≤ 59, s ≤ 59.
  - If all are valid: binary→BCD conversion, registers updated on that edge, tick counter cleared to 0, `load_ack` pulses on the next cycle.
  - If any field is invalid: time is unchanged, the tick counter is unchanged, `load_err` pulses on the next cycle.
- Load and tick in the same cycle: load wins. The tick is discarded and the counter is cleared. `sec_tick` still pulses for that cycle.
- Load while `run`=0 is accepted. The time stays frozen at the loaded value.
- 12 h display (`MODE_12H`=1):
  - Displayed hour = internal hour mod 12, with 0 shown as 12. Internal 00 → 12 AM, 13 → 01 PM.
  - `bcd_h_dez` shows 0 or 1.
- 24 h display: the hour digits show the internal digits directly.
- Seven-segment encoding: standard 0–9 digit patterns, active-low (0 = 7'b1000000). Codes above 9 give all-off (7'b1111111).

## Timing
- Reset (`rst`=1 at a rising edge): time 00:00:00, tick counter 0, `sec_tick`/`load_ack`/`load_err` 0, `pm` 0.
  - Digits after reset: every display shows "0" (7'b1000000), except `bcd_h_unid`/`bcd_h_dez` in 12 h mode, which show "2"/"1" (12 AM).
  - `rst` overrides `load` and `run` in the same cycle.
- `sec_tick` is registered: high in the cycle after the counter register reads DIV-1.
- Time digits and displays update on the edge where the tick counter wraps. The seven-segment outputs are registered with one extra cycle of latency after the time registers.
- The first `sec_tick` after reset or after an accepted load comes DIV cycles later, given continuous `run`=1.
- `load_ack` and `load_err` are mutually exclusive, one cycle each. Back-to-back `load` cycles are each handled independently.

## Test plan
- Reset, `DIV`=4, `run`=1: displays show 00:00:00. `sec_tick` every 4th cycle. After 60 ticks, minutes = 01 and seconds = 00.
- Load h=23, m=59, s=58, `DIV`=1: `load_ack`. Two ticks later the time is 00:00:00 and `pm` falls from 1 to 0.
- Load h=24 (also m=60 separately): `load_err` pulses, `load_ack` stays 0, time unchanged.
- `run`=0 for 20 cycles mid-count: no `sec_tick`, digits frozen. After `run`=1, the tick resumes from the held counter value.
- `MODE_12H`=1: load 00:00:00 → hour digits "12", `pm`=0. Load 13:05:00 → "01", `pm`=1. Load 12:00:00 → "12", `pm`=1.
- `load` asserted in the same cycle as the counter wrap, then `rst` asserted mid-count: the loaded value wins with no extra increment. Reset returns everything to the reset values above on the next edge.
